change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Downstream of the vending-machine controller: consumes the refund/change amount it produces and drives the coin hopper one coin at a time.
- Greedy largest-first selection over denominations 50/10/5/1, skipping empty hoppers.
- Per-coin req/ack handshake with the hopper and an ack timeout.
- Reports completion, coins paid, undispensed remainder and an error code back to the controller.

Parameters:
AMT_W, 8, width of change_amount, remaining and coins_paid
ACK_TIMEOUT, 255, max cycles a coin request is held waiting for hopper_ack (≥1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-low
change_valid  in  1  controller presents a change request
change_amount  in  AMT_W  amount to return, in units of 1
change_ready  out  1  high only in IDLE; a request is accepted when valid and ready are both high
coin_req  out  4  one-hot hopper request: [3]=50, [2]=10, [1]=5, [0]=1
hopper_ack  in  1  hopper has released the requested coin
hopper_empty  in  4  per-denomination empty flags, same bit order as coin_req
done  out  1  one-cycle pulse at end of every accepted request
err  out  1  one-cycle pulse coincident with done when the request failed
err_code  out  2  00 none, 01 NO_CHANGE, 10 TIMEOUT; held until the next acceptance
remaining  out  AMT_W  amount still owed; equals the undispensed amount after an error
coins_paid  out  AMT_W  number of coins released for the current request

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - coin_req, done, err, err_code, remaining and coins_paid are all 0; change_ready=1.
  - coin_req drops immediately, including mid-dispense; the partial request is lost.
- IDLE:
  - change_ready=1.
  - On change_valid: latch remaining=change_amount, clear coins_paid and err_code.
  - Next state is FINISH if the amount is 0, otherwise SELECT.
- SELECT (1 cycle):
  - Choose the largest d in {50,10,5,1} with d ≤ remaining and hopper_empty[d]=0. hopper_empty is sampled only in this state.
  - If no d qualifies: err_code=NO_CHANGE and go to FINISH.
  - Otherwise drive coin_req one-hot for d, clear the timer and go to REQ.
- REQ:
  - coin_req is held stable.
  - On hopper_ack: remaining -= d, coins_paid += 1, coin_req=0, go to GAP.
  - The timer counts REQ cycles. If ACK_TIMEOUT cycles elapse with no ack: coin_req=0, err_code=TIMEOUT, go to FINISH.
  - If ack arrives in the final allowed cycle, the ack wins.
- GAP (1 cycle, coin_req=0):
  - Next state is FINISH if remaining=0, otherwise SELECT.
- FINISH (1 cycle):
  - done=1, and err=1 if err_code≠0.
  - Then return to IDLE.
- Ignored inputs:
  - hopper_ack outside REQ is ignored.
  - change_valid outside IDLE is ignored; change_ready is low there.
- Latency with same-cycle ack: done is high 3N+1 cycles after the acceptance cycle, where N is the number of coins. An amount of 0 gives done 1 cycle after acceptance.
- Arithmetic:
  - Subtraction never underflows because d ≤ remaining is guaranteed.
  - coins_paid ≤ change_amount, so it cannot overflow.
- remaining and coins_paid hold their values after FINISH until the next acceptance.

Decomposition:
- Shared package vm_pkg holds:
  - state enum (IDLE, SELECT, REQ, GAP, FINISH)
  - denomination constants 50/10/5/1 and one-hot bit indices
  - err_code constants
  - The vending-machine controller imports the same denomination constants.
- One natural sub-module, coin_selector: combinational largest-available-denomination picker.
  - Inputs: remaining, hopper_empty.
  - Outputs: one-hot select, denomination value, none_found.

Test Plan:
1. Amount 68, no hoppers empty, ack in the first REQ cycle -> coin_req sequence 50,10,5,1,1,1; coins_paid=6; remaining=0; done 19 cycles after acceptance; err=0.
2. Amount 0 -> no coin_req; done 1 cycle after acceptance; coins_paid=0; err_code=00.
3. Amount 15 with hopper_empty=0100 (10s empty) -> coin_req 5,5,5; coins_paid=3; done with err=0.
4. Amount 3 with hopper_empty=0001 -> no coin_req; done+err pulse; err_code=01; remaining=3; coins_paid=0.
5. ACK_TIMEOUT=8, amount 10, no ack -> coin_req=0100 high exactly 8 cycles then low; done+err; err_code=10; remaining=10. Repeat with ack in the 8th cycle -> success, remaining=0.
6. Reset pulled low during REQ for amount 50 -> coin_req=0 asynchronously, all outputs 0. After release change_ready=1; an ack pulse in IDLE changes nothing; a new request for 5 completes normally.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared vending-machine types: dispenser FSM states, coin denominations and
// their one-hot hopper bit positions, and change-dispense error codes.
package vm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQ,
    ST_GAP,
    ST_FINISH
  } state_e;

  localparam int unsigned DENOM_50 = 50;
  localparam int unsigned DENOM_10 = 10;
  localparam int unsigned DENOM_5  = 5;
  localparam int unsigned DENOM_1  = 1;

  localparam int unsigned BIT_50 = 3;
  localparam int unsigned BIT_10 = 2;
  localparam int unsigned BIT_5  = 1;
  localparam int unsigned BIT_1  = 0;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_NO_CHANGE = 2'b01,
    ERR_TIMEOUT   = 2'b10
  } err_code_e;

endpackage

// File: rtl/coin_selector.sv
// Combinational picker: largest denomination that fits in remaining and whose
// hopper is not empty; none_found when no hopper can make progress.
module coin_selector
  import vm_pkg::*;
#(
  parameter int AMT_W = 8
) (
  input  logic [AMT_W-1:0] remaining,
  input  logic [3:0]       hopper_empty,
  output logic [3:0]       sel,
  output logic [AMT_W-1:0] denom,
  output logic             none_found
);

  always_comb begin
    sel        = '0;
    denom      = '0;
    none_found = 1'b0;
    if (!hopper_empty[BIT_50] && remaining >= AMT_W'(DENOM_50)) begin
      sel[BIT_50] = 1'b1;
      denom       = AMT_W'(DENOM_50);
    end else if (!hopper_empty[BIT_10] && remaining >= AMT_W'(DENOM_10)) begin
      sel[BIT_10] = 1'b1;
      denom       = AMT_W'(DENOM_10);
    end else if (!hopper_empty[BIT_5] && remaining >= AMT_W'(DENOM_5)) begin
      sel[BIT_5] = 1'b1;
      denom      = AMT_W'(DENOM_5);
    end else if (!hopper_empty[BIT_1] && remaining >= AMT_W'(DENOM_1)) begin
      sel[BIT_1] = 1'b1;
      denom      = AMT_W'(DENOM_1);
    end else begin
      none_found = 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin at a time, largest-first, with a per-coin
// req/ack handshake and ack timeout; reports done/err/remaining/coins_paid.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int AMT_W       = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             change_valid,
  input  logic [AMT_W-1:0] change_amount,
  output logic             change_ready,
  output logic [3:0]       coin_req,
  input  logic             hopper_ack,
  input  logic [3:0]       hopper_empty,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [AMT_W-1:0] remaining,
  output logic [AMT_W-1:0] coins_paid
);

  // Timer holds 0..ACK_TIMEOUT-1: the index of the current REQ cycle.
  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [3:0]       coin_req_q, coin_req_d;
  logic [AMT_W-1:0] denom_q, denom_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [AMT_W-1:0] coins_paid_q, coins_paid_d;
  err_code_e        err_code_q, err_code_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [3:0]       sel_onehot;
  logic [AMT_W-1:0] sel_denom;
  logic             sel_none;

  coin_selector #(
    .AMT_W(AMT_W)
  ) u_coin_selector (
    .remaining   (remaining_q),
    .hopper_empty(hopper_empty),
    .sel         (sel_onehot),
    .denom       (sel_denom),
    .none_found  (sel_none)
  );

  always_comb begin
    state_d      = state_q;
    coin_req_d   = coin_req_q;
    denom_d      = denom_q;
    timer_d      = timer_q;
    remaining_d  = remaining_q;
    coins_paid_d = coins_paid_q;
    err_code_d   = err_code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (change_valid) begin
          remaining_d  = change_amount;
          coins_paid_d = '0;
          err_code_d   = ERR_NONE;
          state_d      = (change_amount == '0) ? ST_FINISH : ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (sel_none) begin
          err_code_d = ERR_NO_CHANGE;
          state_d    = ST_FINISH;
        end else begin
          coin_req_d = sel_onehot;
          denom_d    = sel_denom;
          timer_d    = '0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        // An ack in the last allowed cycle beats the timeout.
        if (hopper_ack) begin
          remaining_d  = remaining_q - denom_q;
          coins_paid_d = coins_paid_q + AMT_W'(1);
          coin_req_d   = '0;
          state_d      = ST_GAP;
        end else if (timer_q == TMR_LAST) begin
          coin_req_d = '0;
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_FINISH;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_GAP:    state_d = (remaining_q == '0) ? ST_FINISH : ST_SELECT;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // done/err are registered so they are high exactly during FINISH.
    done_d = (state_d == ST_FINISH);
    err_d  = done_d && (err_code_d != ERR_NONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      coin_req_q   <= '0;
      denom_q      <= '0;
      timer_q      <= '0;
      remaining_q  <= '0;
      coins_paid_q <= '0;
      err_code_q   <= ERR_NONE;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      coin_req_q   <= coin_req_d;
      denom_q      <= denom_d;
      timer_q      <= timer_d;
      remaining_q  <= remaining_d;
      coins_paid_q <= coins_paid_d;
      err_code_q   <= err_code_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign change_ready = (state_q == ST_IDLE);
  assign coin_req     = coin_req_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign remaining    = remaining_q;
  assign coins_paid   = coins_paid_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed and random requests checked against a
// transaction-level greedy payout model with a scripted hopper.
module tb_change_dispenser;

  localparam int AMT_W = 8;
  localparam int TMO   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             change_valid;
  logic [AMT_W-1:0] change_amount;
  logic             change_ready;
  logic [3:0]       coin_req;
  logic             hopper_ack;
  logic [3:0]       hopper_empty;
  logic             done;
  logic             err;
  logic [1:0]       err_code;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] coins_paid;

  change_dispenser #(.AMT_W(AMT_W), .ACK_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .change_valid (change_valid),
    .change_amount(change_amount),
    .change_ready (change_ready),
    .coin_req     (coin_req),
    .hopper_ack   (hopper_ack),
    .hopper_empty (hopper_empty),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .remaining    (remaining),
    .coins_paid   (coins_paid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Hopper script: plan[k] = REQ cycles of delay before acking coin k, -1 = never.
  int plan[256];
  // Model results for the current request.
  int m_den[256];
  int m_len[256];
  int m_n, m_lat, m_code, m_rem, m_paid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_plan(input int v);
    for (int i = 0; i < 256; i++) plan[i] = v;
  endtask

  function automatic int den_of(input logic [3:0] oh);
    case (oh)
      4'b1000: return 50;
      4'b0100: return 10;
      4'b0010: return 5;
      4'b0001: return 1;
      default: return -1;
    endcase
  endfunction

  // Greedy payout with cycle accounting per coin: select 1, request delay+1, gap 1;
  // plus 1 for the finish cycle.
  task automatic model(input int amount, input logic [3:0] empty);
    int vals[4];
    int bits[4];
    int rem, d;
    vals = '{50, 10, 5, 1};
    bits = '{3, 2, 1, 0};
    rem = amount; m_lat = 1; m_n = 0; m_code = 0; m_paid = 0;
    while (rem > 0) begin
      d = 0;
      for (int i = 0; i < 4; i++)
        if (d == 0 && !empty[bits[i]] && vals[i] <= rem) d = vals[i];
      m_lat += 1;
      if (d == 0) begin
        m_code = 1;
        break;
      end
      m_den[m_n] = d;
      if (plan[m_n] < 0) begin
        m_len[m_n] = TMO;
        m_n++;
        m_lat += TMO;
        m_code = 2;
        break;
      end
      m_len[m_n] = plan[m_n] + 1;
      m_lat += plan[m_n] + 2;
      m_n++;
      rem -= d;
      m_paid++;
    end
    m_rem = rem;
  endtask

  task automatic run(input int amount, input logic [3:0] empty, input bit noise);
    int cyc, ncoin, plen, guard;
    logic [3:0] prev;
    bit seen;
    int obs_den[256];
    int obs_len[256];
    model(amount, empty);
    guard = 0;
    while (change_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_req", change_ready, 1);
    hopper_empty  = empty;
    change_amount = AMT_W'(amount);
    change_valid  = 1'b1;
    hopper_ack    = 1'b0;
    @(negedge clk);
    change_valid = 1'b0;
    cyc = 1; ncoin = 0; plen = 0; prev = '0; seen = 1'b0;
    while (!seen && cyc <= m_lat + TMO + 10) begin
      if (coin_req != 4'b0) begin
        if (prev == 4'b0) begin
          obs_den[ncoin] = den_of(coin_req);
          plen = 1;
          check("coin_onehot", $countones(coin_req), 1);
        end else begin
          plen++;
          check("coin_stable", coin_req, prev);
        end
      end else if (prev != 4'b0) begin
        obs_len[ncoin] = plen;
        ncoin++;
      end
      prev = coin_req;
      if (coin_req != 4'b0) hopper_ack = (plan[ncoin] >= 0) && (plan[ncoin] == plen - 1);
      else hopper_ack = noise ? 1'($urandom % 2) : 1'b0;
      check("ready_busy", change_ready, 0);
      if (done === 1'b1) begin
        seen = 1'b1;
        change_valid = 1'b0;
        check("done_latency", cyc, m_lat);
        check("err_pulse", err, (m_code != 0) ? 1 : 0);
        check("err_code", err_code, m_code);
        check("remaining", remaining, m_rem);
        check("coins_paid", coins_paid, m_paid);
      end else begin
        check("err_without_done", err, 0);
        if (noise) begin
          change_valid  = 1'($urandom % 2);
          change_amount = AMT_W'($urandom);
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (!seen) check("done_seen", 0, 1);
    check("coin_count", ncoin, m_n);
    for (int i = 0; i < ncoin && i < m_n; i++) begin
      check("coin_denom", obs_den[i], m_den[i]);
      check("coin_req_len", obs_len[i], m_len[i]);
    end
    hopper_ack   = 1'b0;
    change_valid = 1'b0;
    check("idle_ready", change_ready, 1);
    check("idle_done", done, 0);
    check("idle_err", err, 0);
    check("hold_err_code", err_code, m_code);
    check("hold_remaining", remaining, m_rem);
    check("hold_coins_paid", coins_paid, m_paid);
  endtask

  initial begin
    int g;
    rst = 1'b0;
    change_valid = 1'b0;
    change_amount = '0;
    hopper_ack = 1'b0;
    hopper_empty = '0;
    @(negedge clk);
    check("rst_coin_req", coin_req, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_remaining", remaining, 0);
    check("rst_coins_paid", coins_paid, 0);
    check("rst_ready", change_ready, 1);
    rst = 1'b1;
    @(negedge clk);

    // Hand-computed values pinning the model.
    set_plan(0);
    model(68, 4'b0000);
    check("pin68_lat", m_lat, 19);
    check("pin68_paid", m_paid, 6);
    check("pin68_coin0", m_den[0], 50);
    check("pin68_coin3", m_den[3], 1);
    model(15, 4'b0100);
    check("pin15_paid", m_paid, 3);
    check("pin15_coin", m_den[1], 5);
    model(3, 4'b0001);
    check("pin3_code", m_code, 1);
    check("pin3_rem", m_rem, 3);
    check("pin3_lat", m_lat, 2);
    plan[0] = -1;
    model(10, 4'b0000);
    check("pin_tmo_lat", m_lat, 10);
    check("pin_tmo_len", m_len[0], 8);

    set_plan(0);
    run(68, 4'b0000, 1'b0);
    run(0, 4'b0000, 1'b0);
    run(15, 4'b0100, 1'b0);
    run(3, 4'b0001, 1'b0);
    plan[0] = -1;
    run(10, 4'b0000, 1'b0);
    plan[0] = TMO - 1;
    run(10, 4'b0000, 1'b0);

    for (int it = 0; it < 40; it++) begin
      int r;
      for (int i = 0; i < 256; i++) begin
        r = int'($urandom % 40);
        plan[i] = (r == 0) ? -1 : (r < 3) ? TMO - 1 : int'($urandom % 4);
      end
      run(int'($urandom % 256), 4'($urandom & $urandom & $urandom), 1'b1);
    end

    // Asynchronous reset while a 50 is being requested.
    set_plan(-1);
    hopper_empty = '0;
    change_amount = 8'd50;
    change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    g = 0;
    while (coin_req == 4'b0 && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("pre_rst_coin_req", coin_req, 4'b1000);
    #2 rst = 1'b0;
    #1;
    check("arst_coin_req", coin_req, 0);
    check("arst_remaining", remaining, 0);
    check("arst_coins_paid", coins_paid, 0);
    check("arst_done", done, 0);
    check("arst_err_code", err_code, 0);
    check("arst_ready", change_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    hopper_ack = 1'b1;
    @(negedge clk);
    hopper_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_coin_req", coin_req, 0);
    check("idle_ack_remaining", remaining, 0);
    check("idle_ack_coins_paid", coins_paid, 0);
    check("idle_ack_done", done, 0);
    check("idle_ack_ready", change_ready, 1);
    set_plan(0);
    run(5, 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
